// File: rtl/gambit_dispatch_pkg.sv
// gambit_dispatch_pkg: class-flag struct, dispatch FSM states and barrier mask for gambit_dispatch_ctrl
package gambit_dispatch_pkg;
  typedef struct packed {
    logic alu;
    logic alu0;
    logic fpu;
    logic fpu0;
    logic mem;
    logic fc;
    logic sync;
    logic fsync;
    logic memsb;
    logic memdb;
  } dispatch_cls_t;
  typedef enum logic {RUN, BWAIT} dispatch_state_e;
  localparam logic [9:0] BARRIER_MASK = 10'b00_0000_1111;
endpackage

// File: rtl/gambit_dispatch_fifo.sv
// gambit_dispatch_fifo: DEPTH x W FIFO with flush; ports clk/rst_n, flush, wr_en/wr_data, rd_en/rd_data (head, combinational), full/empty
module gambit_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic we, re;
  assign re = rd_en && !empty;
  assign we = wr_en && (!full || re);
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (we) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + (AW+1)'(1);
      if (re) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/gambit_dispatch_ctrl.sv
// gambit_dispatch_ctrl: in-order one-per-cycle dispatch of decoded class flags to ALU0/ALU1/FPU/MEM/FC with in-flight counters and barriers
// Ports: clk_i, rst_ni (async low), flush_i; decode side dec_valid_i/dec_ready_o/dec_cls_i/dec_tag_i;
// per unit <u>_valid_o/<u>_ready_i/<u>_tag_o; completions int_done_i/fp_done_i/mem_done_i; busy_o.
// Macro GAMBIT_DUAL_ALU_EN enables the ALU1 port; otherwise every ALU op goes to ALU0.
module gambit_dispatch_ctrl
  import gambit_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW = 6,
  parameter int CNTW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            dec_valid_i,
  output logic            dec_ready_o,
  input  logic [9:0]      dec_cls_i,
  input  logic [TAGW-1:0] dec_tag_i,
  output logic            alu0_valid_o,
  input  logic            alu0_ready_i,
  output logic [TAGW-1:0] alu0_tag_o,
  output logic            alu1_valid_o,
  input  logic            alu1_ready_i,
  output logic [TAGW-1:0] alu1_tag_o,
  output logic            fpu_valid_o,
  input  logic            fpu_ready_i,
  output logic [TAGW-1:0] fpu_tag_o,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [TAGW-1:0] mem_tag_o,
  output logic            fc_valid_o,
  input  logic            fc_ready_i,
  output logic [TAGW-1:0] fc_tag_o,
  input  logic            int_done_i,
  input  logic            fp_done_i,
  input  logic            mem_done_i,
  output logic            busy_o
);
  localparam logic [CNTW-1:0] CMAX = '1;
  dispatch_state_e state;
  dispatch_cls_t h;
  logic [9+TAGW:0] h_word;
  logic [TAGW-1:0] h_tag;
  logic [CNTW-1:0] cnt_int, cnt_fp, cnt_mem;
  logic full, empty, hv, deq, is_bar, is_int, is_fp, is_mem, is_fc, nop, stall, go, bar_ok, sel_alu1;
  logic hs_int, hs_fp, hs_mem;
  function automatic logic [CNTW-1:0] nxt(input logic [CNTW-1:0] c, input logic inc, input logic dn);
    return c + CNTW'(inc) - CNTW'(dn && c != '0);
  endfunction
  gambit_dispatch_fifo #(.DEPTH(DEPTH), .W(10 + TAGW)) u_fifo (
    .clk(clk_i), .rst_n(rst_ni), .flush(flush_i),
    .wr_en(dec_valid_i && !full), .wr_data({dec_cls_i, dec_tag_i}),
    .rd_en(deq), .rd_data(h_word), .full(full), .empty(empty)
  );
  assign h = dispatch_cls_t'(h_word[9+TAGW -: 10]);
  assign h_tag = h_word[TAGW-1:0];
  assign hv = !empty;
  assign is_bar = |(h & BARRIER_MASK);
  // Route priority when several op bits are set: ALU, then FPU, MEM, FC
  assign is_int = h.alu0 | h.alu;
  assign is_fp = !is_int && (h.fpu | h.fpu0);
  assign is_mem = !is_int && !is_fp && h.mem;
  assign is_fc = !is_int && !is_fp && !is_mem && h.fc;
  assign nop = !(is_int | is_fp | is_mem | is_fc);
  // A saturated domain stalls unless a completion frees a slot this same cycle
  assign stall = (is_int | is_fc) ? (cnt_int == CMAX && !int_done_i) :
                 is_fp ? (cnt_fp == CMAX && !fp_done_i) :
                 is_mem ? (cnt_mem == CMAX && !mem_done_i) : 1'b0;
  assign go = hv && state == RUN && !is_bar && !stall;
`ifdef GAMBIT_DUAL_ALU_EN
  // Plain ALU ops prefer ALU1 and fall back to ALU0 only when ALU0 can take them
  assign sel_alu1 = h.alu && !h.alu0 && (alu1_ready_i || !alu0_ready_i);
`else
  assign sel_alu1 = 1'b0;
`endif
  assign alu0_valid_o = go && is_int && !sel_alu1;
  assign alu1_valid_o = go && is_int && sel_alu1;
  assign fpu_valid_o = go && is_fp;
  assign mem_valid_o = go && is_mem;
  assign fc_valid_o = go && is_fc;
  assign alu0_tag_o = alu0_valid_o ? h_tag : '0;
  assign alu1_tag_o = alu1_valid_o ? h_tag : '0;
  assign fpu_tag_o = fpu_valid_o ? h_tag : '0;
  assign mem_tag_o = mem_valid_o ? h_tag : '0;
  assign fc_tag_o = fc_valid_o ? h_tag : '0;
  assign hs_int = (alu0_valid_o && alu0_ready_i) || (alu1_valid_o && alu1_ready_i) || (fc_valid_o && fc_ready_i);
  assign hs_fp = fpu_valid_o && fpu_ready_i;
  assign hs_mem = mem_valid_o && mem_ready_i;
  assign bar_ok = (!h.sync || (cnt_int == '0 && cnt_fp == '0 && cnt_mem == '0)) &&
                  (!h.fsync || cnt_fp == '0) && (!(h.memsb || h.memdb) || cnt_mem == '0);
  assign deq = hv && (state == RUN ? go && (nop || hs_int || hs_fp || hs_mem) : bar_ok);
  assign dec_ready_o = !full;
  assign busy_o = hv || cnt_int != '0 || cnt_fp != '0 || cnt_mem != '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= RUN;
      cnt_int <= '0;
      cnt_fp <= '0;
      cnt_mem <= '0;
    end else begin
      cnt_int <= nxt(cnt_int, hs_int, int_done_i);
      cnt_fp <= nxt(cnt_fp, hs_fp, fp_done_i);
      cnt_mem <= nxt(cnt_mem, hs_mem, mem_done_i);
      state <= flush_i ? RUN : state == RUN ? ((hv && is_bar) ? BWAIT : RUN) : (bar_ok ? RUN : BWAIT);
    end
endmodule

// File: tb/tb_gambit_dispatch_ctrl.sv
// tb_gambit_dispatch_ctrl: directed + random stimulus against a queue-based reference model with an issue scoreboard
module tb_gambit_dispatch_ctrl;
  localparam int DEPTH = 4;
`ifdef GAMBIT_DUAL_ALU_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam logic [9:0] C_ALU = 10'h200, C_FPU = 10'h080, C_MEM = 10'h020, C_SYNC = 10'h008;
  logic clk, rst_ni, flush_i, dec_valid_i, dec_ready_o, busy_o;
  logic [9:0] dec_cls_i;
  logic [5:0] dec_tag_i;
  logic alu0_valid_o, alu1_valid_o, fpu_valid_o, mem_valid_o, fc_valid_o;
  logic alu0_ready_i, alu1_ready_i, fpu_ready_i, mem_ready_i, fc_ready_i;
  logic [5:0] alu0_tag_o, alu1_tag_o, fpu_tag_o, mem_tag_o, fc_tag_o;
  logic int_done_i, fp_done_i, mem_done_i;
  gambit_dispatch_ctrl #(.DEPTH(DEPTH), .TAGW(6), .CNTW(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_cls_i(dec_cls_i), .dec_tag_i(dec_tag_i),
    .alu0_valid_o(alu0_valid_o), .alu0_ready_i(alu0_ready_i), .alu0_tag_o(alu0_tag_o),
    .alu1_valid_o(alu1_valid_o), .alu1_ready_i(alu1_ready_i), .alu1_tag_o(alu1_tag_o),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_tag_o(fpu_tag_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_tag_o(mem_tag_o),
    .fc_valid_o(fc_valid_o), .fc_ready_i(fc_ready_i), .fc_tag_o(fc_tag_o),
    .int_done_i(int_done_i), .fp_done_i(fp_done_i), .mem_done_i(mem_done_i), .busy_o(busy_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {logic [9:0] cls; logic [5:0] tag;} ent_t;
  ent_t mq[$];
  int exp_q[$];
  int cnt[3];
  bit bw;
  int n_chk = 0, n_fail = 0;
  logic [4:0] vld, hsv;
  logic [5:0] tgv [5];
  assign vld = {fc_valid_o, mem_valid_o, fpu_valid_o, alu1_valid_o, alu0_valid_o};
  assign hsv = vld & {fc_ready_i, mem_ready_i, fpu_ready_i, alu1_ready_i, alu0_ready_i};
  assign tgv[0] = alu0_tag_o;
  assign tgv[1] = alu1_tag_o;
  assign tgv[2] = fpu_tag_o;
  assign tgv[3] = mem_tag_o;
  assign tgv[4] = fc_tag_o;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int route(input logic [9:0] c, input logic [4:0] r);
    if (c[8]) return 0;
    if (c[9]) return (DUAL && (r[1] || !r[0])) ? 1 : 0;
    if (c[7] || c[6]) return 2;
    if (c[5]) return 3;
    if (c[4]) return 4;
    return -1;
  endfunction
  function automatic bit bar_ok(input logic [9:0] c);
    return (!c[3] || (cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0)) && (!c[2] || cnt[1] == 0) &&
           (!(c[1] || c[0]) || cnt[2] == 0);
  endfunction
  task automatic step(input bit dv, input logic [9:0] cls, input logic [5:0] tag,
                      input logic [4:0] r, input logic [2:0] d, input bit fl);
    logic [4:0] ev;
    logic [9:0] c;
    bit deq, nbw, bsy;
    int inc[3];
    int sz, u, dm;
    ev = '0; deq = 0; nbw = 0; inc = '{0, 0, 0}; sz = mq.size();
    @(posedge clk);
    #1;
    dec_valid_i = dv; dec_cls_i = cls; dec_tag_i = tag; flush_i = fl;
    {fc_ready_i, mem_ready_i, fpu_ready_i, alu1_ready_i, alu0_ready_i} = r;
    {mem_done_i, fp_done_i, int_done_i} = d;
    bsy = sz > 0 || cnt[0] > 0 || cnt[1] > 0 || cnt[2] > 0;
    if (sz > 0) begin
      c = mq[0].cls;
      if (bw) deq = bar_ok(c);
      else if (|c[3:0]) nbw = 1;
      else begin
        u = route(c, r);
        if (u < 0) deq = 1;
        else begin
          dm = u == 2 ? 1 : u == 3 ? 2 : 0;
          if (cnt[dm] < 15 || d[dm]) begin
            ev[u] = 1'b1;
            if (r[u]) begin
              deq = 1;
              inc[dm] = 1;
              exp_q.push_back(u * 64 + int'(mq[0].tag));
            end
          end
        end
      end
    end
    #2;
    chk("valids", 32'(vld), 32'(ev));
    chk("dec_ready", 32'(dec_ready_o), 32'(sz < DEPTH));
    chk("busy", 32'(busy_o), 32'(bsy));
    for (int k = 0; k < 3; k++) cnt[k] = cnt[k] + inc[k] - ((d[k] && cnt[k] > 0) ? 1 : 0);
    if (fl) begin
      mq.delete();
      bw = 0;
    end else begin
      bw = bw ? !deq : nbw;
      if (deq) void'(mq.pop_front());
      if (dv && sz < DEPTH) mq.push_back('{cls, tag});
    end
  endtask
  always @(negedge clk)
    if (rst_ni)
      for (int u = 0; u < 5; u++)
        if (hsv[u]) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue: got unit %0d tag %0d, expected no issue", u, tgv[u]);
          end else chk("issue", 32'(u * 64 + int'(tgv[u])), 32'(exp_q.pop_front()));
        end
  function automatic logic [9:0] rcls();
    int k = $urandom_range(0, 10);
    return k == 10 ? 10'd0 : 10'd1 << k;
  endfunction
  function automatic logic [4:0] rbits5();
    logic [4:0] b;
    for (int i = 0; i < 5; i++) b[i] = $urandom_range(0, 3) != 0;
    return b;
  endfunction
  function automatic logic [2:0] rbits3();
    logic [2:0] b;
    for (int i = 0; i < 3; i++) b[i] = $urandom_range(0, 2) == 0;
    return b;
  endfunction
  task automatic idle(input int n, input logic [4:0] r, input logic [2:0] d);
    repeat (n) step(0, '0, '0, r, d, 0);
  endtask
  int t;
  initial begin
    rst_ni = 0; flush_i = 0; dec_valid_i = 0; dec_cls_i = '0; dec_tag_i = '0;
    {alu0_ready_i, alu1_ready_i, fpu_ready_i, mem_ready_i, fc_ready_i} = '0;
    {int_done_i, fp_done_i, mem_done_i} = '0;
    cnt = '{0, 0, 0}; bw = 0;
    #3;
    chk("rst_valids", 32'(vld), 0);
    chk("rst_dec_ready", 32'(dec_ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    @(negedge clk);
    rst_ni = 1;
    for (int i = 0; i < 5; i++) step(1, C_ALU, 6'(i), '0, '0, 0);
    step(0, '0, '0, '0, '0, 0);
    chk("full_ready", 32'(dec_ready_o), 0);
    chk("full_head_valid", 32'(DUAL ? alu1_valid_o : alu0_valid_o), 1);
    chk("full_head_tag", 32'(DUAL ? alu1_tag_o : alu0_tag_o), 0);
    idle(6, 5'h1f, '0);
    idle(6, 5'h1f, 3'b001);
    step(1, C_FPU, 10, 5'h1f, '0, 0);
    step(1, C_SYNC, 11, 5'h1f, '0, 0);
    step(1, C_ALU, 12, 5'h1f, '0, 0);
    idle(10, 5'h1f, '0);
    idle(1, 5'h1f, 3'b010);
    idle(4, 5'h1f, 3'b001);
    t = 0;
    repeat (24) begin
      step(1, C_MEM, 6'(t), 5'h08, '0, 0);
      t++;
    end
    step(0, '0, '0, 5'h08, 3'b100, 0);
    idle(4, 5'h08, '0);
    idle(24, 5'h1f, 3'b111);
    step(1, C_MEM, 30, 5'h08, '0, 0);
    step(1, C_ALU, 31, 5'h08, '0, 0);
    step(1, C_ALU, 32, '0, '0, 0);
    step(1, C_ALU, 33, '0, '0, 0);
    step(1, C_ALU, 34, '0, '0, 1);
    idle(4, '0, '0);
    chk("flush_busy", 32'(busy_o), 1);
    idle(3, '0, 3'b100);
    step(1, C_ALU, 40, 5'b00001, '0, 0);
    step(0, '0, '0, 5'b00001, '0, 0);
    idle(3, '0, 3'b001);
    repeat (800) step($urandom_range(0, 1), rcls(), 6'($urandom), rbits5(), rbits3(), $urandom_range(0, 31) == 0);
    idle(24, 5'h1f, 3'b111);
    step(1, C_FPU, 20, 5'h1f, '0, 0);
    step(1, C_SYNC, 21, 5'h1f, '0, 0);
    idle(3, 5'h1f, '0);
    #1;
    rst_ni = 0;
    #1;
    chk("arst_valids", 32'(vld), 0);
    chk("arst_dec_ready", 32'(dec_ready_o), 1);
    chk("arst_busy", 32'(busy_o), 0);
    mq.delete(); exp_q.delete(); cnt = '{0, 0, 0}; bw = 0;
    @(negedge clk);
    rst_ni = 1;
    step(1, C_ALU, 50, 5'h1f, '0, 0);
    idle(2, 5'h1f, '0);
    repeat (200) step($urandom_range(0, 1), rcls(), 6'($urandom), rbits5(), rbits3(), $urandom_range(0, 31) == 0);
    idle(30, 5'h1f, 3'b111);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
